pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 102 ++++++++++
 tb/tb_pipe_skid_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid) with hold and flush.
// Latency: one cycle from accept to out_valid; one payload per cycle at full throughput.
// Backpressure: in_ready is registered-state only (skid empty, no hold, no flush); it never looks at out_ready.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and head payload
//   hold_flag_i              - pipeline hold level; stall when >= HOLD_LVL
//   flush_i                  - synchronous discard of both entries
//   occupancy                - number of entries held (0..2)
module pipe_skid_reg #(
    parameter int                  DW       = 32,
    parameter logic [DW-1:0]       RST_VAL  = '0,
    parameter int                  HOLD_W   = 3,
    parameter logic [HOLD_W-1:0]   HOLD_LVL = HOLD_W'(3'b010)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              flush_i,
    output logic [1:0]        occupancy
);

    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [DW-1:0] main_dat_q, main_dat_d;
    logic [DW-1:0] skid_dat_q, skid_dat_d;

    logic hold;
    logic accept;
    logic take;

    assign hold = (hold_flag_i >= HOLD_LVL);

    // rst gates in_ready so upstream sees no acceptance while reset is held.
    assign in_ready  = rst && !skid_vld_q && !hold && !flush_i;
    assign out_valid = main_vld_q && !hold;
    assign out_data  = main_dat_q;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;

        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_dat_d = RST_VAL;
            skid_dat_d = RST_VAL;
        end else if (!hold) begin
            if (!main_vld_q) begin
                // Skid is never valid without main, so only main can load here.
                if (accept) begin
                    main_vld_d = 1'b1;
                    main_dat_d = in_data;
                end
            end else if (take) begin
                if (skid_vld_q) begin
                    // in_ready is low while skid is full, so no accept competes here.
                    main_dat_d = skid_dat_q;
                    skid_vld_d = 1'b0;
                    skid_dat_d = RST_VAL;
                end else if (accept) begin
                    main_dat_d = in_data;
                end else begin
                    main_vld_d = 1'b0;
                    main_dat_d = RST_VAL;
                end
            end else if (accept) begin
                skid_vld_d = 1'b1;
                skid_dat_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_dat_q <= RST_VAL;
            skid_dat_q <= RST_VAL;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, async reset sequence,
// and a random run against a queue model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pipe_skid_reg;

    localparam int          DW   = 8;
    localparam logic [7:0]  RV   = 8'hE5;
    localparam int          NV   = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] hold_flag_i = '0;
    logic       flush_i = 1'b0;
    logic [1:0] occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .DW       (DW),
        .RST_VAL  (RV),
        .HOLD_W   (3),
        .HOLD_LVL (3'b010)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .hold_flag_i (hold_flag_i),
        .flush_i     (flush_i),
        .occupancy   (occupancy)
    );

    typedef struct packed {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic [2:0] hf;
        logic       fl;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [1:0] occ;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ir, input logic ov,
                            input logic [7:0] od, input logic [1:0] occ);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_data"},  32'(out_data),  32'(od));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic [2:0] hf, input logic fl);
        in_valid    = iv;
        in_data     = id;
        out_ready   = ordy;
        hold_flag_i = hf;
        flush_i     = fl;
    endtask

    // Random-phase model state
    logic [7:0] mq [$];

    initial begin
        // Each row: inputs for one cycle, and the outputs expected during that cycle
        //           iv    id     ordy  hf    fl    ir    ov    od     occ
        // Streaming 0x11,0x22,0x33 at full rate
        vecs[0]  = {1'b1, 8'h11, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        vecs[1]  = {1'b1, 8'h22, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
        vecs[2]  = {1'b1, 8'h33, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'h22, 2'd1};
        vecs[3]  = {1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'h33, 2'd1};
        vecs[4]  = {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        // Fill both entries with out_ready low, then drain in order
        vecs[5]  = {1'b1, 8'h0A, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        vecs[6]  = {1'b1, 8'h0B, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd1};
        vecs[7]  = {1'b1, 8'h0C, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
        vecs[8]  = {1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd2};
        vecs[9]  = {1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'h0B, 2'd1};
        vecs[10] = {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        // Hold at/above level for 3 cycles, then release (level 1 is below threshold)
        vecs[11] = {1'b1, 8'h3C, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        vecs[12] = {1'b1, 8'h77, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h3C, 2'd1};
        vecs[13] = {1'b1, 8'h77, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h3C, 2'd1};
        vecs[14] = {1'b1, 8'h77, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'h3C, 2'd1};
        vecs[15] = {1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd1};
        vecs[16] = {1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        // Flush with both entries full, hold active and 0x55 offered
        vecs[17] = {1'b1, 8'hA1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        vecs[18] = {1'b1, 8'hA2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1};
        vecs[19] = {1'b1, 8'h55, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'hA1, 2'd2};
        vecs[20] = {1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        // Flush beats a simultaneous take and accept
        vecs[21] = {1'b1, 8'h66, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};
        vecs[22] = {1'b1, 8'h99, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h66, 2'd1};
        vecs[23] = {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RV,    2'd0};

        // Reset state while rst is held low
        #12;
        chk_outs("reset", 1'b0, 1'b0, RV, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs("post_reset", 1'b1, 1'b0, RV, 2'd0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].hf, vecs[i].fl);
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i].ir, vecs[i].ov, vecs[i].od, vecs[i].occ);
        end

        // Asynchronous reset between edges with two entries held
        @(negedge clk); drive(1'b1, 8'hC1, 1'b0, 3'd0, 1'b0);
        @(negedge clk); drive(1'b1, 8'hC2, 1'b0, 3'd0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        #1;
        chk("arst.pre_occ", 32'(occupancy), 32'd2);
        #1;
        rst = 1'b0;
        #1;
        chk_outs("arst.mid", 1'b0, 1'b0, RV, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
        #1;
        chk_outs("arst.rel", 1'b1, 1'b0, RV, 2'd0);
        @(negedge clk);
        #1;
        chk_outs("arst.rel2", 1'b1, 1'b0, RV, 2'd0);

        // Random traffic against a queue model
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            logic       iv, ordy, fl, hold, e_ir, e_ov;
            logic [2:0] hf;
            logic [7:0] id, e_od;
            @(negedge clk);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 31) == 0);
            hf   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            id   = 8'($urandom);
            drive(iv, id, ordy, hf, fl);
            #1;
            hold = (hf >= 3'd2);
            e_ir = (mq.size() < 2) && !hold && !fl;
            e_ov = (mq.size() > 0) && !hold;
            e_od = (mq.size() > 0) ? mq[0] : RV;
            chk_outs($sformatf("rnd%0d", c), e_ir, e_ov, e_od, 2'(mq.size()));
            if (fl) begin
                mq.delete();
            end else begin
                if (e_ov && ordy) void'(mq.pop_front());
                if (iv && e_ir) mq.push_back(id);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
